// File: rtl/flit_age_stamper.sv
// flit_age_stamper: injection-side flit buffer that stamps every waiting flit
// with a non-zero, saturating age and presents the head flit (payload + age)
// to the router. It also produces the arbiter priority mode bit, which flips
// every MODE_PERIOD cycles regardless of traffic.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. in_ready depends only on registered occupancy, so it has no
// combinational path from out_ready. out_valid/out_data/out_time come
// straight from storage. Age 0 means "no flit": an entry's age is non-zero
// exactly when that entry is occupied.
module flit_age_stamper #(
  parameter int WIDTH_TIME  = 8,
  parameter int MAX_TIME    = 255,
  parameter int WIDTH_DATA  = 64,
  parameter int DEPTH       = 4,
  parameter int MODE_PERIOD = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic [WIDTH_DATA-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [WIDTH_DATA-1:0] out_data,
  output logic [WIDTH_TIME-1:0] out_time,
  input  logic                  out_ready,
  output logic                  mode
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = (MODE_PERIOD > 1) ? $clog2(MODE_PERIOD) : 1;

  localparam logic [PTR_W:0]      FULL_COUNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]      COUNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0]    PTR_ONE    = PTR_W'(1);
  localparam logic [WIDTH_TIME-1:0] AGE_MAX  = WIDTH_TIME'(MAX_TIME);
  localparam logic [WIDTH_TIME-1:0] AGE_ONE  = WIDTH_TIME'(1);
  localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(MODE_PERIOD - 1);
  localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);

  // Storage and pointers
  logic [WIDTH_DATA-1:0] data_q [DEPTH];
  logic [WIDTH_DATA-1:0] data_d [DEPTH];
  logic [WIDTH_TIME-1:0] age_q  [DEPTH];
  logic [WIDTH_TIME-1:0] age_d  [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]        count_q,  count_d;

  // Mode generator
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  mode_q, mode_d;

  logic                  enq;
  logic                  deq;

  // Handshake flags and head presentation, all derived from registered state
  always_comb begin
    in_ready  = (count_q != FULL_COUNT);
    out_valid = (count_q != '0);
    enq       = in_valid && in_ready;
    deq       = out_valid && out_ready;
    out_data  = out_valid ? data_q[rd_ptr_q] : '0;
    out_time  = out_valid ? age_q[rd_ptr_q]  : '0;
    mode      = mode_q;
  end

  // FIFO next state: age occupied entries, free the head on dequeue, write tail on enqueue
  always_comb begin
    data_d   = data_q;
    age_d    = age_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    for (int i = 0; i < DEPTH; i++) begin
      if (age_q[i] != '0) begin
        age_d[i] = (age_q[i] == AGE_MAX) ? AGE_MAX : age_q[i] + AGE_ONE;
      end
    end

    // The head slot is cleared so an empty slot always reads age 0 / data 0.
    if (deq) begin
      age_d[rd_ptr_q]  = '0;
      data_d[rd_ptr_q] = '0;
      rd_ptr_d         = rd_ptr_q + PTR_ONE;
    end

    // Enqueue only happens when not full, so the tail never aliases a
    // head that is being dequeued in the same cycle.
    if (enq) begin
      age_d[wr_ptr_q]  = AGE_ONE;
      data_d[wr_ptr_q] = in_data;
      wr_ptr_d         = wr_ptr_q + PTR_ONE;
    end

    case ({enq, deq})
      2'b10:   count_d = count_q + COUNT_ONE;
      2'b01:   count_d = count_q - COUNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Mode phase counter: flip mode when the counter wraps
  always_comb begin
    cnt_d  = cnt_q + CNT_ONE;
    mode_d = mode_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      mode_d = ~mode_q;
    end
  end

  // State registers; reset drops all buffered flits and restarts the mode phase
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        age_q[i]  <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
    end else begin
      data_q   <= data_d;
      age_q    <= age_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
    end
  end

endmodule

// File: doc/flit_age_stamper.md
Name: flit_age_stamper

Overview:
- Injection-side producer of the flit time field consumed by the permutation-network arbiters.
- Accepts local flits through a valid/ready handshake and buffers them in a small FIFO.
- Stamps each flit with a non-zero, saturating age that grows every cycle it waits, and presents the head flit with its age to the router.
- Also generates the arbiter priority mode bit, which toggles periodically for fairness.

Parameters:
- WIDTH_TIME, 8: width of the time/age field; matches `WIDTH_TIME.
- MAX_TIME, 255: saturation value of age (2^WIDTH_TIME-1); matches `MAX_TIME.
- WIDTH_DATA, 64: flit payload width.
- DEPTH, 4: FIFO entries; power of two, ≥2.
- MODE_PERIOD, 16: cycles per mode phase; ≥1.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  local flit offered.
- in_data  in  WIDTH_DATA  local flit payload.
- in_ready  out  1  FIFO can accept.
- out_valid  out  1  head flit present.
- out_data  out  WIDTH_DATA  head payload.
- out_time  out  WIDTH_TIME  head age; 0 only when out_valid=0.
- out_ready  in  1  router takes head this cycle.
- mode  out  1  arbiter priority mode, 0 or 1.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While reset_n=0, all state clears immediately:
  - FIFO empty, pointers 0, every stored age 0.
  - in_ready=1, out_valid=0, out_data=0, out_time=0.
  - mode=0, phase counter 0.
- Reset mid-operation: all buffered flits are dropped; nothing is emitted after release.
- Encoding: time value 0 is reserved for "no flit". Every stored flit has age in 1..MAX_TIME.
- Enqueue: occurs when in_valid && in_ready at a clock edge. The flit is written at the tail with age=1.
- in_ready = !full. It is registered/state-derived, with no combinational path from out_ready.
  - A full FIFO with simultaneous dequeue still shows in_ready=0 that cycle.
- Dequeue:
  - out_valid = !empty.
  - out_data and out_time come from the head entry, driven from storage (zero input-to-output latency is not required).
  - The head is removed at the edge when out_valid && out_ready.
  - out_data=0 and out_time=0 while empty.
- Ageing: at each edge, every occupied entry not dequeued at that edge updates as age <= (age==MAX_TIME) ? MAX_TIME : age+1.
  - Ageing never wraps to 0.
  - A newly enqueued entry is written with 1, not 2.
- Latency:
  - A flit accepted at edge N appears with out_valid=1 and out_time=1 after edge N when the FIFO was empty.
  - Its age is 1+k after k further edges without dequeue.
- Simultaneous enqueue and dequeue (not full): both occur, occupancy unchanged, FIFO order preserved.
- Empty with in_valid: no bypass; the flit is visible the next cycle.
- Pointers: wrap modulo DEPTH. Full/empty are distinguished by an occupancy counter of width log2(DEPTH)+1.
- Mode generator:
  - Counter cnt runs 0..MODE_PERIOD-1 continuously.
  - At the edge where cnt==MODE_PERIOD-1, cnt<=0 and mode<=~mode.
  - The first toggle occurs at edge MODE_PERIOD after reset release.
  - mode is independent of FIFO traffic.
- No X propagation: unwritten storage reads as 0.

Test Plan:
- Reset then idle 20 cycles (MODE_PERIOD=16) -> in_ready=1, out_valid=0, out_time=0 throughout; mode rises to 1 after the 16th edge and stays 1 through edge 20.
- Enqueue A with out_ready=0, hold 3 edges -> out_valid=1, out_time reads 1,2,3,4 over successive cycles; out_data=A.
- Fill 4 flits A..D with out_ready=0 -> in_ready=0 after the 4th accept; a 5th offer is not accepted. Then drain one per cycle -> order A,B,C,D, with ages of B..D each at least their wait time.
- Single entry held 300 cycles (WIDTH_TIME=8) -> out_time saturates at 255 and never shows 0; on dequeue, out_time=0 and out_valid=0.
- Continuous in_valid=1 and out_ready=1 from empty -> steady state of one flit per cycle, each emitted with out_time=1, occupancy 1.
- Assert reset_n=0 asynchronously with 3 flits buffered and mode=1 -> outputs return to reset values before the next edge; after release, 0 flits are emitted and mode=0.
